// File: rtl/sync_counter_pkg.sv
// Shared constants, next-state operation encoding and terminal-state helper
// for the parametrised synchronous counter family.
package sync_counter_pkg;

   localparam logic        CNT_UP    = 1'b1;
   localparam logic        CNT_DOWN  = 1'b0;
   localparam int unsigned MAX_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_CLEAR,
      OP_LOAD,
      OP_UP,
      OP_DOWN
   } cnt_op_e;

   // Terminal state for a direction: MODULUS-1 going up, 0 going down.
   // The mask keeps MODULUS=2**WIDTH from producing a bit above WIDTH.
   function automatic logic [MAX_WIDTH-1:0] terminal_value(
      input logic            up,
      input longint unsigned modulus,
      input int unsigned     width
   );
      longint unsigned mask;
      mask = (width >= MAX_WIDTH) ? 64'h0000_0000_FFFF_FFFF
                                  : ((64'd1 << width) - 64'd1);
      return (up == CNT_UP) ? 32'((modulus - 64'd1) & mask) : '0;
   endfunction

   function automatic logic params_legal(
      input int unsigned     width,
      input longint unsigned modulus
   );
      logic ok;
      ok = (width >= 1) && (width <= MAX_WIDTH);
      if (ok) begin
         ok = (modulus >= 64'd2) && (modulus <= (64'd1 << width));
      end
      return ok;
   endfunction

endpackage

// File: rtl/sync_counter_term.sv
// Terminal-count detector shared by the ripple-carry output and the wrap
// decision; also flags loaded states that lie outside the count range.
module sync_counter_term
   import sync_counter_pkg::*;
#(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MODULUS = 16
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic             up_i,
   output logic             term_o,
   output logic             oor_o
);

   localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(terminal_value(CNT_UP, MODULUS, WIDTH));
   localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(terminal_value(CNT_DOWN, MODULUS, WIDTH));

   logic at_last;
   logic at_zero;

   assign at_last = (q_i == TERM_UP);
   assign at_zero = (q_i == TERM_DN);

   assign term_o = (up_i == CNT_UP) ? at_last : at_zero;

   // Never true when MODULUS=2**WIDTH, since TERM_UP is then all ones.
   assign oor_o  = (q_i > TERM_UP);

endmodule

// File: rtl/sync_counter_n.sv
// Parametrised synchronous binary counter: clear/load/ENP/ENT behave like
// the TTL 4-bit counters, plus modulus, up/down and a registered wrap pulse.
module sync_counter_n
   import sync_counter_pkg::*;
#(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MODULUS = 16
) (
   input  logic             _CLK,
   input  logic             _RST,
   input  logic             _CLR,
   input  logic             _LOAD,
   input  logic             _ENP,
   input  logic             _ENT,
   input  logic             _UP,
   input  logic [WIDTH-1:0] _DATA,
   output logic [WIDTH-1:0] _Q,
   output logic             _RCO,
   output logic             _TC
);

   if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
      $fatal(1, "sync_counter_n: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
   end

   localparam logic [WIDTH-1:0] LAST = WIDTH'(terminal_value(CNT_UP, MODULUS, WIDTH));
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             tc_q, tc_d;
   logic             term;
   logic             oor;
   cnt_op_e          op;

   sync_counter_term #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_term (
      .q_i    (q_q),
      .up_i   (_UP),
      .term_o (term),
      .oor_o  (oor)
   );

   always_comb begin
      op = OP_HOLD;
      if (!_CLR) begin
         op = OP_CLEAR;
      end else if (!_LOAD) begin
         op = OP_LOAD;
      end else if (_ENP && _ENT) begin
         op = (_UP == CNT_UP) ? OP_UP : OP_DOWN;
      end
   end

   // Out-of-range states fold onto the wrap target: up pulses TC, down does not.
   always_comb begin
      q_d  = q_q;
      tc_d = 1'b0;
      case (op)
         OP_CLEAR: q_d = '0;
         OP_LOAD:  q_d = _DATA;
         OP_UP: begin
            if (term || oor) begin
               q_d  = '0;
               tc_d = 1'b1;
            end else begin
               q_d  = q_q + ONE;
            end
         end
         OP_DOWN: begin
            if (term) begin
               q_d  = LAST;
               tc_d = 1'b1;
            end else if (oor) begin
               q_d  = LAST;
            end else begin
               q_d  = q_q - ONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge _CLK or negedge _RST) begin
      if (!_RST) begin
         q_q  <= '0;
         tc_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         tc_q <= tc_d;
      end
   end

   assign _Q   = q_q;
   assign _TC  = tc_q;
   assign _RCO = _ENT & term;

endmodule

// File: tb/tb_sync_counter_n.sv
// Bench for sync_counter_n: a modulus-10 counter under directed and random
// stimulus, a MODULUS=2**WIDTH 1-bit counter, and a two-stage cascade.
module tb_sync_counter_n;

   localparam int AW = 4;
   localparam int AM = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic          a_clr, a_load, a_enp, a_ent, a_up;
   logic [AW-1:0] a_data, a_q;
   logic          a_rco, a_tc;

   logic b_q, b_rco, b_tc;

   logic       c_clr, c_load, c_enp, c_ent;
   logic [3:0] c_data, lo_q, hi_q;
   logic       lo_rco, lo_tc, hi_rco, hi_tc;

   int   n_cmp = 0;
   int   n_mis = 0;

   int   mq, bq;
   logic mtc, btc;

   sync_counter_n #(.WIDTH(AW), .MODULUS(AM)) dut_a (
      ._CLK(clk), ._RST(rst_n), ._CLR(a_clr), ._LOAD(a_load), ._ENP(a_enp),
      ._ENT(a_ent), ._UP(a_up), ._DATA(a_data), ._Q(a_q), ._RCO(a_rco), ._TC(a_tc)
   );

   sync_counter_n #(.WIDTH(1), .MODULUS(2)) dut_b (
      ._CLK(clk), ._RST(rst_n), ._CLR(1'b1), ._LOAD(1'b1), ._ENP(1'b1),
      ._ENT(1'b1), ._UP(1'b1), ._DATA(1'b0), ._Q(b_q), ._RCO(b_rco), ._TC(b_tc)
   );

   sync_counter_n #(.WIDTH(4), .MODULUS(16)) dut_lo (
      ._CLK(clk), ._RST(rst_n), ._CLR(c_clr), ._LOAD(c_load), ._ENP(c_enp),
      ._ENT(c_ent), ._UP(1'b1), ._DATA(c_data), ._Q(lo_q), ._RCO(lo_rco), ._TC(lo_tc)
   );

   sync_counter_n #(.WIDTH(4), .MODULUS(16)) dut_hi (
      ._CLK(clk), ._RST(rst_n), ._CLR(c_clr), ._LOAD(c_load), ._ENP(c_enp),
      ._ENT(lo_rco), ._UP(1'b1), ._DATA(4'd0), ._Q(hi_q), ._RCO(hi_rco), ._TC(hi_tc)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   function automatic logic exp_rco();
      return a_ent && (a_up ? (mq == AM - 1) : (mq == 0));
   endfunction

   task automatic model_reset();
      mq  = 0;
      mtc = 1'b0;
      bq  = 0;
      btc = 1'b0;
   endtask

   // Reference: apply the counter rules to the inputs present at the coming edge.
   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
      end else begin
         if (!a_clr) begin
            mq = 0; mtc = 1'b0;
         end else if (!a_load) begin
            mq = int'(a_data); mtc = 1'b0;
         end else if (a_enp && a_ent) begin
            if (a_up) begin
               mtc = (mq + 1 >= AM);
               mq  = (mq + 1 >= AM) ? 0 : mq + 1;
            end else begin
               mtc = (mq == 0);
               mq  = (mq == 0 || mq >= AM) ? AM - 1 : mq - 1;
            end
         end else begin
            mtc = 1'b0;
         end
         btc = (bq == 1);
         bq  = (bq + 1) % 2;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      chk("a_q",   64'(a_q),   64'(mq));
      chk("a_tc",  64'(a_tc),  64'(mtc));
      chk("a_rco", 64'(a_rco), 64'(exp_rco()));
      chk("b_q",   64'(b_q),   64'(bq));
      chk("b_tc",  64'(b_tc),  64'(btc));
      chk("b_rco", 64'(b_rco), 64'(bq == 1));
   endtask

   // Reset pulse between edges: outputs must clear without any clock.
   task automatic async_rst_pulse(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk({tag, "_q"},  64'(a_q),  64'(0));
      chk({tag, "_tc"}, 64'(a_tc), 64'(0));
      chk({tag, "_bq"}, 64'(b_q),  64'(0));
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n  = 1'b0;
      a_clr  = 1'b1; a_load = 1'b1; a_enp = 1'b1; a_ent = 1'b1; a_up = 1'b1;
      a_data = '0;
      c_clr  = 1'b1; c_load = 1'b1; c_enp = 1'b0; c_ent = 1'b1; c_data = '0;
      model_reset();

      repeat (3) tick();
      a_up = 1'b0;
      #1;
      chk("rst_rco_down", 64'(a_rco), 64'(1));
      a_up = 1'b1;
      #1;
      chk("rst_rco_up", 64'(a_rco), 64'(0));

      rst_n = 1'b1;
      repeat (12) tick();

      a_load = 1'b0; a_data = 4'd2; a_up = 1'b0;
      tick();
      a_load = 1'b1;
      repeat (3) tick();
      a_up = 1'b1;
      #1;
      chk("dir_rco", 64'(a_rco), 64'(1));
      tick();

      a_load = 1'b0; a_data = 4'd5;
      tick();
      a_clr = 1'b0; a_data = 4'd7;
      tick();
      a_clr = 1'b1;

      a_data = 4'd13;
      tick();
      a_load = 1'b1; a_up = 1'b1;
      tick();
      a_load = 1'b0;
      tick();
      a_load = 1'b1; a_up = 1'b0;
      tick();

      a_up = 1'b1; a_load = 1'b0; a_data = 4'd8;
      tick();
      a_load = 1'b1;
      tick();
      async_rst_pulse("arst_mid");
      a_load = 1'b0; a_data = 4'd9;
      tick();
      a_load = 1'b1;
      tick();
      async_rst_pulse("arst_wrap");

      for (int i = 0; i < 500; i++) begin
         a_clr  = ($urandom_range(0, 19) != 0);
         a_load = ($urandom_range(0, 9) != 0);
         a_enp  = ($urandom_range(0, 3) != 0);
         a_ent  = ($urandom_range(0, 3) != 0);
         a_up   = ($urandom_range(0, 1) != 0);
         a_data = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) async_rst_pulse("arst_rand");
         #1;
         chk("rco_comb", 64'(a_rco), 64'(exp_rco()));
         tick();
      end
      a_clr = 1'b1; a_load = 1'b1; a_enp = 1'b0;

      c_load = 1'b0; c_data = 4'd15;
      tick();
      chk("lo_load15", 64'(lo_q), 64'(15));
      c_load = 1'b1; c_enp = 1'b0; c_ent = 1'b1;
      #1;
      chk("lo_rco_enp0", 64'(lo_rco), 64'(1));
      tick();
      chk("lo_hold", 64'(lo_q), 64'(15));
      chk("hi_hold", 64'(hi_q), 64'(0));
      c_ent = 1'b0;
      #1;
      chk("lo_rco_ent0", 64'(lo_rco), 64'(0));

      c_clr = 1'b0;
      tick();
      chk("cas_clr", 64'({hi_q, lo_q}), 64'(0));
      c_clr = 1'b1; c_enp = 1'b1; c_ent = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         tick();
         chk("cas", 64'({hi_q, lo_q}), 64'(k % 256));
      end
      chk("cas_300", 64'({hi_q, lo_q}), 64'(44));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
